// File: rtl/display_pkg.sv
// Shared constants and state encoding for the seven-segment value formatter.
package display_pkg;

    localparam logic [4:0]  AN_BLANK = 5'b10000;
    localparam logic [4:0]  AN_ERR   = 5'b01110;
    localparam logic [15:0] DEC_MAX  = 16'd9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } state_e;

    // Unblanked digit code: blank bit clear, hex digit in the low nibble.
    function automatic logic [4:0] digit_code(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

endpackage

// File: rtl/bcd_add3_step.sv
// Double-dabble correction: add 3 to every BCD digit >= 5, no carry between digits.
module bcd_add3_step
    import display_pkg::*;
(
    input  logic [15:0] bcd_i,
    output logic [15:0] bcd_o
);

    always_comb begin
        bcd_o = bcd_i;
        for (int i = 0; i < 4; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/display_value_formatter.sv
// Converts a 16-bit value into four registered digit codes (hex or decimal),
// with optional leading-zero blanking and decimal overflow indication.
//
// state | meaning
// IDLE  | waiting for load_i; captures value, mode and blank flag
// CONV  | one double-dabble step per cycle, 16 steps total
// FMT   | registers digit codes into AN3..AN0 and pulses done_o
module display_value_formatter
    import display_pkg::*;
(
    input  logic        clk100M,
    input  logic        rst,
    input  logic [15:0] value_i,
    input  logic        dec_mode_i,
    input  logic        blank_lz_i,
    input  logic        load_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [4:0]  AN3,
    output logic [4:0]  AN2,
    output logic [4:0]  AN1,
    output logic [4:0]  AN0
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] val_q, val_d;
    logic        dec_q, dec_d;
    logic        blank_q, blank_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  an3_q, an3_d, an2_q, an2_d, an1_q, an1_d, an0_q, an0_d;

    logic [15:0] bcd_adj;
    logic [15:0] digits;
    logic        lz3, lz2, lz1;
    logic [4:0]  fmt3, fmt2, fmt1, fmt0;

    bcd_add3_step u_add3 (
        .bcd_i (bcd_q),
        .bcd_o (bcd_adj)
    );

    // Digit codes as they would be shown; only registered in FMT.
    always_comb begin
        digits = dec_q ? bcd_q : val_q;
        lz3    = blank_q && (digits[15:12] == 4'd0);
        lz2    = lz3 && (digits[11:8] == 4'd0);
        lz1    = lz2 && (digits[7:4] == 4'd0);
        fmt3   = lz3 ? AN_BLANK : digit_code(digits[15:12]);
        fmt2   = lz2 ? AN_BLANK : digit_code(digits[11:8]);
        fmt1   = lz1 ? AN_BLANK : digit_code(digits[7:4]);
        fmt0   = digit_code(digits[3:0]);
        if (ovf_q) begin
            fmt3 = AN_ERR;
            fmt2 = AN_ERR;
            fmt1 = AN_ERR;
            fmt0 = AN_ERR;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        val_d   = val_q;
        dec_d   = dec_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        an3_d   = an3_q;
        an2_d   = an2_q;
        an1_d   = an1_q;
        an0_d   = an0_q;

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    val_d   = value_i;
                    dec_d   = dec_mode_i;
                    blank_d = blank_lz_i;
                    ovf_d   = dec_mode_i && (value_i > DEC_MAX);
                    if (dec_mode_i) begin
                        bin_d   = value_i;
                        bcd_d   = 16'd0;
                        cnt_d   = 4'd0;
                        state_d = CONV;
                    end else begin
                        state_d = FMT;
                    end
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[14:0], bin_q[15]};
                bin_d = {bin_q[14:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FMT;
                end
            end
            FMT: begin
                an3_d   = fmt3;
                an2_d   = fmt2;
                an1_d   = fmt1;
                an0_d   = fmt0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk100M) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            bin_q   <= 16'd0;
            bcd_q   <= 16'd0;
            val_q   <= 16'd0;
            dec_q   <= 1'b0;
            blank_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            an3_q   <= AN_BLANK;
            an2_q   <= AN_BLANK;
            an1_q   <= AN_BLANK;
            an0_q   <= AN_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            val_q   <= val_d;
            dec_q   <= dec_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            an3_q   <= an3_d;
            an2_q   <= an2_d;
            an1_q   <= an1_d;
            an0_q   <= an0_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign AN3    = an3_q;
    assign AN2    = an2_q;
    assign AN1    = an1_q;
    assign AN0    = an0_q;

endmodule

// File: tb/tb_display_value_formatter.sv
// Directed self-checking bench for display_value_formatter.
module tb_display_value_formatter;

    logic        clk100M = 1'b0;
    logic        rst;
    logic [15:0] value_i;
    logic        dec_mode_i;
    logic        blank_lz_i;
    logic        load_i;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  AN3, AN2, AN1, AN0;

    int checks   = 0;
    int failures = 0;

    localparam logic [19:0] ALL_BLANK = {4{5'b10000}};
    localparam logic [19:0] ALL_ERR   = {4{5'b01110}};

    display_value_formatter dut (
        .clk100M    (clk100M),
        .rst        (rst),
        .value_i    (value_i),
        .dec_mode_i (dec_mode_i),
        .blank_lz_i (blank_lz_i),
        .load_i     (load_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .AN3        (AN3),
        .AN2        (AN2),
        .AN1        (AN1),
        .AN0        (AN0)
    );

    always #5 clk100M = ~clk100M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a load for exactly one edge; caller is #1 after an edge with the DUT idle.
    task automatic do_load(input logic [15:0] v, input logic dec, input logic blk);
        value_i    = v;
        dec_mode_i = dec;
        blank_lz_i = blk;
        load_i     = 1'b1;
        @(posedge clk100M);
        #1;
        load_i = 1'b0;
        chk("busy_after_load", {31'd0, busy_o}, 32'd1);
    endtask

    // Counts edges until done_o is observed high; bounded.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk100M);
            #1;
            n++;
        end while (!done_o && n < 40);
        chk({tag, "_done_seen"}, {31'd0, done_o}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [15:0] v, input logic dec,
                       input logic blk, input logic [19:0] exp_an);
        int n;
        do_load(v, dec, blk);
        wait_done(tag, n);
        chk({tag, "_latency"}, n, dec ? 32'd17 : 32'd1);
        chk({tag, "_an"}, {12'd0, AN3, AN2, AN1, AN0}, {12'd0, exp_an});
        chk({tag, "_busy_low"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        rst        = 1'b1;
        value_i    = 16'd0;
        dec_mode_i = 1'b0;
        blank_lz_i = 1'b0;
        load_i     = 1'b0;
        repeat (3) @(posedge clk100M);
        #1;
        chk("reset_an", {12'd0, AN3, AN2, AN1, AN0}, {12'd0, ALL_BLANK});
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_done", {31'd0, done_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk100M);
        #1;

        run("hex_beef", 16'hBEEF, 1'b0, 1'b0, {5'b01011, 5'b01110, 5'b01110, 5'b01111});
        @(posedge clk100M);
        #1;
        chk("done_one_cycle", {31'd0, done_o}, 32'd0);

        // Reset in the middle of a decimal conversion.
        do_load(16'd1234, 1'b1, 1'b1);
        repeat (7) @(posedge clk100M);
        #1;
        rst = 1'b1;
        @(posedge clk100M);
        #1;
        rst = 1'b0;
        chk("midrst_an", {12'd0, AN3, AN2, AN1, AN0}, {12'd0, ALL_BLANK});
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk100M);
            #1;
            if (done_o) seen++;
        end
        chk("midrst_no_done", seen, 32'd0);

        run("dec_1234", 16'd1234, 1'b1, 1'b1, {5'b00001, 5'b00010, 5'b00011, 5'b00100});
        run("dec_0042", 16'd42, 1'b1, 1'b1, {5'b10000, 5'b10000, 5'b00100, 5'b00010});
        run("dec_0", 16'd0, 1'b1, 1'b1, {5'b10000, 5'b10000, 5'b10000, 5'b00000});
        run("dec_0042_noblank", 16'd42, 1'b1, 1'b0, {5'b00000, 5'b00000, 5'b00100, 5'b00010});
        run("dec_10000", 16'd10000, 1'b1, 1'b1, ALL_ERR);
        run("dec_65535", 16'd65535, 1'b1, 1'b0, ALL_ERR);
        run("dec_9999", 16'd9999, 1'b1, 1'b1, {4{5'b01001}});
        run("dec_0907", 16'd907, 1'b1, 1'b1, {5'b10000, 5'b01001, 5'b00000, 5'b00111});
        run("hex_00a0_blank", 16'h00A0, 1'b0, 1'b1, {5'b10000, 5'b10000, 5'b01010, 5'b00000});
        run("hex_ffff_noovf", 16'hFFFF, 1'b0, 1'b1, {4{5'b01111}});

        // Load while busy is ignored.
        do_load(16'd5678, 1'b1, 1'b0);
        repeat (4) @(posedge clk100M);
        #1;
        value_i    = 16'h1111;
        dec_mode_i = 1'b0;
        load_i     = 1'b1;
        @(posedge clk100M);
        #1;
        load_i  = 1'b0;
        value_i = 16'h2222;
        wait_done("busy_load", n);
        chk("busy_load_latency", n, 32'd12);
        chk("busy_load_an", {12'd0, AN3, AN2, AN1, AN0},
            {12'd0, 5'b00101, 5'b00110, 5'b00111, 5'b01000});
        @(posedge clk100M);
        #1;
        chk("busy_load_no_requeue", {31'd0, busy_o}, 32'd0);

        // Back-to-back hex with load held high.
        value_i    = 16'h1234;
        dec_mode_i = 1'b0;
        blank_lz_i = 1'b0;
        load_i     = 1'b1;
        wait_done("b2b_hex_first", n);
        wait_done("b2b_hex_second", n);
        chk("b2b_hex_interval", n, 32'd2);
        chk("b2b_hex_an", {12'd0, AN3, AN2, AN1, AN0},
            {12'd0, 5'b00001, 5'b00010, 5'b00011, 5'b00100});
        load_i = 1'b0;
        @(posedge clk100M);
        #1;
        @(posedge clk100M);
        #1;

        // Back-to-back decimal with load held high.
        value_i    = 16'd805;
        dec_mode_i = 1'b1;
        blank_lz_i = 1'b1;
        load_i     = 1'b1;
        wait_done("b2b_dec_first", n);
        wait_done("b2b_dec_second", n);
        chk("b2b_dec_interval", n, 32'd18);
        chk("b2b_dec_an", {12'd0, AN3, AN2, AN1, AN0},
            {12'd0, 5'b10000, 5'b01000, 5'b00000, 5'b00101});
        load_i = 1'b0;
        repeat (20) @(posedge clk100M);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
